// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory request/response bundle between the fetch stage and
//   the instruction memory.
//
//   imem_req    fetch request valid (fetch side drives)
//   imem_addr   fetch address (fetch side drives)
//   imem_ready  memory returns imem_rdata this cycle (memory drives)
//   imem_rdata  instruction word (memory drives)
//
//   modport master : fetch stage view
//   modport slave  : instruction memory view
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of a 5-stage MIPS pipeline: PC register,
//   instruction-memory handshake, one-entry fetch buffer and the IF/ID
//   pipeline register.
//
//   Parameters
//     RESET_PC      PC loaded on reset
//     NOP_INSTR     word placed in IF/ID for a bubble or flush
//
//   Ports
//     clk           pipeline clock, rising edge
//     reset         asynchronous, active-high
//     PCWrite       0 = hold PC (hazard stall)
//     IFIDWrite     0 = hold IF/ID (hazard stall)
//     BranchTaken   redirect PC and flush IF/ID (honoured only with PCWrite)
//     BranchTarget  redirect address; bits [1:0] forced to 0
//     imem          fetch_stage_if.master instruction-memory handshake
//     PC            current fetch PC
//     IFID_PC4      PC+4 of the instruction in IF/ID
//     IFID_Instr    instruction in IF/ID
//     IFID_Valid    1 = real instruction, 0 = bubble
//     fetch_stall   1 = waiting on instruction memory
//     BubbleCnt     saturating count of bubbles loaded into IF/ID
//                   (present only when FETCH_PERF_EN is defined)
//
//   Optional feature macro: FETCH_PERF_EN
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                PCWrite,
    input  logic                IFIDWrite,
    input  logic                BranchTaken,
    input  logic [31:0]         BranchTarget,
    fetch_stage_if.master       imem,
    output logic [31:0]         PC,
    output logic [31:0]         IFID_PC4,
    output logic [31:0]         IFID_Instr,
    output logic                IFID_Valid,
`ifdef FETCH_PERF_EN
    output logic                fetch_stall,
    output logic [31:0]         BubbleCnt
`else
    output logic                fetch_stall
`endif
);

    // REQ: request outstanding. BUF: fetched word parked, IF/ID stalled.
    typedef enum logic {REQ, BUF} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_d;
    logic [31:0] ifid_pc4_d, ifid_instr_d;
    logic        ifid_valid_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        load_bubble;

    logic        adv;
    logic        redirect;
    logic [31:0] pc_plus4;

    // A stall on either side holds the PC, so PC never runs ahead of IF/ID.
    assign adv      = PCWrite & IFIDWrite;
    // A branch stalled in ID (PCWrite=0) must not redirect yet.
    assign redirect = BranchTaken & PCWrite;
    // 32-bit add wraps naturally: 32'hFFFF_FFFC -> 32'h0000_0000.
    assign pc_plus4 = PC + 32'd4;

    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = PC;
    assign fetch_stall    = (state_q == REQ) && !imem.imem_ready;

    // NOTE: every signal written here gets a hold/default value first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = PC;
        ifid_pc4_d   = IFID_PC4;
        ifid_instr_d = IFID_Instr;
        ifid_valid_d = IFID_Valid;
        buf_pc4_d    = buf_pc4_q;
        buf_instr_d  = buf_instr_q;
        load_bubble  = 1'b0;

        if (redirect) begin
            // Redirect wins over everything; a same-cycle imem_ready is dropped
            // and any parked word is discarded by returning to REQ.
            pc_d         = {BranchTarget[31:2], 2'b00};
            ifid_pc4_d   = 32'h0000_0000;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            state_d      = REQ;
            load_bubble  = 1'b1;
        end else begin
            case (state_q)
                REQ: begin
                    if (imem.imem_ready) begin
                        if (adv) begin
                            ifid_pc4_d   = pc_plus4;
                            ifid_instr_d = imem.imem_rdata;
                            ifid_valid_d = 1'b1;
                            pc_d         = pc_plus4;
                        end else begin
                            // Memory will not replay, so park the word.
                            buf_pc4_d   = pc_plus4;
                            buf_instr_d = imem.imem_rdata;
                            state_d     = BUF;
                        end
                    end else if (IFIDWrite) begin
                        ifid_pc4_d   = 32'h0000_0000;
                        ifid_instr_d = NOP_INSTR;
                        ifid_valid_d = 1'b0;
                        load_bubble  = 1'b1;
                    end
                end
                BUF: begin
                    if (adv) begin
                        ifid_pc4_d   = buf_pc4_q;
                        ifid_instr_d = buf_instr_q;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_plus4;
                        state_d      = REQ;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= REQ;
            PC          <= RESET_PC;
            IFID_PC4    <= 32'h0000_0000;
            IFID_Instr  <= NOP_INSTR;
            IFID_Valid  <= 1'b0;
            buf_pc4_q   <= 32'h0000_0000;
            buf_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            PC          <= pc_d;
            IFID_PC4    <= ifid_pc4_d;
            IFID_Instr  <= ifid_instr_d;
            IFID_Valid  <= ifid_valid_d;
            buf_pc4_q   <= buf_pc4_d;
            buf_instr_q <= buf_instr_d;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating bubble counter (imem wait or flush).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            BubbleCnt <= 32'h0000_0000;
        end else if (load_bubble && (BubbleCnt != 32'hFFFF_FFFF)) begin
            BubbleCnt <= BubbleCnt + 32'd1;
        end
    end
`else
    logic unused_bubble;
    assign unused_bubble = load_bubble;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. Memory returns addr ^ 32'hA5A5_A5A5.
//   A reference model tracks PC/IF/ID; accepted fetches are pushed onto a
//   scoreboard queue and popped when they enter IF/ID.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] MASK   = 32'hA5A5_A5A5;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write, ifid_write, branch_taken, ready;
    logic [31:0] branch_target;
    logic [31:0] pc, ifid_pc4, ifid_instr;
    logic        ifid_valid, fetch_stall;
`ifdef FETCH_PERF_EN
    logic [31:0] bubble_cnt;
`endif

    fetch_stage_if imem_bus ();

    assign imem_bus.imem_ready = ready;
    assign imem_bus.imem_rdata = imem_bus.imem_addr ^ MASK;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .PCWrite      (pc_write),
        .IFIDWrite    (ifid_write),
        .BranchTaken  (branch_taken),
        .BranchTarget (branch_target),
        .imem         (imem_bus),
        .PC           (pc),
        .IFID_PC4     (ifid_pc4),
        .IFID_Instr   (ifid_instr),
        .IFID_Valid   (ifid_valid),
`ifdef FETCH_PERF_EN
        .fetch_stall  (fetch_stall),
        .BubbleCnt    (bubble_cnt)
`else
        .fetch_stall  (fetch_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_valid;
    logic [31:0] m_bub;
    entry_t      sbq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_pc4   = 32'h0;
        m_instr = NOP;
        m_valid = 1'b0;
        m_bub   = 32'h0;
        sbq.delete();
    endtask

    task automatic model_bubble();
        m_pc4   = 32'h0;
        m_instr = NOP;
        m_valid = 1'b0;
        if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
    endtask

    task automatic model_pop();
        entry_t e;
        e       = sbq.pop_front();
        m_pc4   = e.pc4;
        m_instr = e.instr;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
    endtask

    // Apply one rising edge to the model from the bench-driven inputs.
    task automatic model_edge();
        logic adv;
        adv = pc_write & ifid_write;
        if (branch_taken && pc_write) begin
            m_pc = branch_target & 32'hFFFF_FFFC;
            sbq.delete();
            model_bubble();
        end else if (sbq.size() == 0) begin
            if (ready) begin
                sbq.push_back('{pc4: m_pc + 32'd4, instr: m_pc ^ MASK});
                if (adv) model_pop();
            end else if (ifid_write) begin
                model_bubble();
            end
        end else if (adv) begin
            model_pop();
        end
    endtask

    task automatic compare_all();
        check("pc",      pc,                 m_pc);
        check("addr",    imem_bus.imem_addr, m_pc);
        check("pc4",     ifid_pc4,           m_pc4);
        check("instr",   ifid_instr,         m_instr);
        check("valid",   32'(ifid_valid),    32'(m_valid));
        check("req",     32'(imem_bus.imem_req), 32'(sbq.size() == 0));
        check("stall",   32'(fetch_stall),   32'((sbq.size() == 0) && !ready));
`ifdef FETCH_PERF_EN
        check("bubcnt",  bubble_cnt,         m_bub);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_in(input logic pw, input logic iw, input logic bt,
                          input logic [31:0] tgt, input logic rdy);
        pc_write      = pw;
        ifid_write    = iw;
        branch_taken  = bt;
        branch_target = tgt;
        ready         = rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pc_hold;
        logic [31:0] bub_start;

        reset = 1'b1;
        set_in(1, 1, 0, 32'h0, 1);
        model_reset();
        @(negedge clk);
        check("rst_pc",    pc,                     RST_PC);
        check("rst_pc4",   ifid_pc4,               32'h0);
        check("rst_instr", ifid_instr,             NOP);
        check("rst_valid", 32'(ifid_valid),        32'h0);
        check("rst_req",   32'(imem_bus.imem_req), 32'h1);
        reset = 1'b0;

        // Free-running fetch from reset.
        repeat (3) step();
        check("run_pc",    pc,       32'h0040_000C);
        check("run_pc4",   ifid_pc4, 32'h0040_000C);
        check("run_instr", ifid_instr, 32'h0040_0008 ^ MASK);
        check("run_valid", 32'(ifid_valid), 32'h1);

        // Hazard stall with memory ready: word parks in the buffer.
        set_in(0, 0, 0, 32'h0, 1);
        repeat (2) step();
        check("stl_pc",  pc,       32'h0040_000C);
        check("stl_pc4", ifid_pc4, 32'h0040_000C);
        check("stl_req", 32'(imem_bus.imem_req), 32'h0);
        set_in(1, 1, 0, 32'h0, 1);
        step();
        check("rel_pc4",   ifid_pc4,   32'h0040_0010);
        check("rel_instr", ifid_instr, 32'h0040_000C ^ MASK);
        step();
        check("res_pc4",   ifid_pc4,   32'h0040_0014);
        check("res_instr", ifid_instr, 32'h0040_0010 ^ MASK);

        // Memory wait: bubbles into IF/ID, PC frozen.
        pc_hold   = pc;
        bub_start = m_bub;
        set_in(1, 1, 0, 32'h0, 0);
        repeat (3) begin
            step();
            check("wait_stall", 32'(fetch_stall), 32'h1);
            check("wait_valid", 32'(ifid_valid),  32'h0);
            check("wait_instr", ifid_instr,       NOP);
            check("wait_pc",    pc,               pc_hold);
        end
`ifdef FETCH_PERF_EN
        check("wait_bub", bubble_cnt - bub_start, 32'd3);
`endif

        // Branch while in BUF: buffer dropped, target aligned.
        set_in(0, 0, 0, 32'h0, 1);
        step();
        check("buf_req", 32'(imem_bus.imem_req), 32'h0);
        set_in(1, 1, 1, 32'h0000_1003, 1);
        step();
        check("br_pc",    pc,                     32'h0000_1000);
        check("br_valid", 32'(ifid_valid),        32'h0);
        check("br_req",   32'(imem_bus.imem_req), 32'h1);
        set_in(1, 1, 0, 32'h0, 1);
        step();
        check("br_pc4",   ifid_pc4,   32'h0000_1004);
        check("br_instr", ifid_instr, 32'hA5A5_B5A5);

        // Branch with PCWrite=0 is ignored.
        set_in(0, 0, 1, 32'h0000_2000, 1);
        step();
        check("ign_pc",  pc,       32'h0000_1004);
        check("ign_pc4", ifid_pc4, 32'h0000_1004);
        // PCWrite without IFIDWrite still stalls.
        set_in(1, 0, 0, 32'h0, 1);
        step();
        check("pw_pc", pc, 32'h0000_1004);
        set_in(1, 1, 0, 32'h0, 1);
        step();
        check("pw_pc4", ifid_pc4, 32'h0000_1008);

        // PC wrap.
        set_in(1, 1, 1, 32'hFFFF_FFFF, 1);
        step();
        check("wr_pc0", pc, 32'hFFFF_FFFC);
        set_in(1, 1, 0, 32'h0, 1);
        step();
        check("wr_pc",    pc,         32'h0000_0000);
        check("wr_pc4",   ifid_pc4,   32'h0000_0000);
        check("wr_instr", ifid_instr, 32'h5A5A_5A59);
        check("wr_valid", 32'(ifid_valid), 32'h1);

        // Randomised mix of stalls, waits and branches.
        for (int i = 0; i < 40; i++) begin
            set_in(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 8) == 0,
                   $urandom, ($urandom % 3) != 0);
            step();
        end

        // Async reset in the middle of a memory wait.
        set_in(1, 1, 0, 32'h0, 0);
        step();
        #2 reset = 1'b1;
        #1;
        check("ar_pc",    pc,                     RST_PC);
        check("ar_pc4",   ifid_pc4,               32'h0);
        check("ar_instr", ifid_instr,             NOP);
        check("ar_valid", 32'(ifid_valid),        32'h0);
        check("ar_req",   32'(imem_bus.imem_req), 32'h1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        set_in(1, 1, 0, 32'h0, 1);
        repeat (2) step();
        check("ar_run_pc", pc, RST_PC + 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, instruction-memory request handshake, one-entry fetch buffer and the IF/ID pipeline register.
- Sits directly upstream of the hazard detection unit.
- Consumes its PCWrite/IFIDWrite stall controls and the ID-stage branch redirect.
- Produces IFID_Instr, whose Rs/Rt fields feed the hazard check.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID on bubble/flush (sll $0,$0,0)

Ports:
clk  input  1  pipeline clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
PCWrite  input  1  from hazard unit; 0 = hold PC (stall)
IFIDWrite  input  1  from hazard unit; 0 = hold IF/ID register (stall)
BranchTaken  input  1  from ID stage; redirect PC and flush IF/ID
BranchTarget  input  32  redirect address, word aligned
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (= PC)
imem_ready  input  1  memory returns imem_rdata this cycle for imem_addr
imem_rdata  input  32  instruction word
PC  output  32  current fetch PC
IFID_PC4  output  32  PC+4 of instruction in IF/ID
IFID_Instr  output  32  instruction in IF/ID
IFID_Valid  output  1  1 = real instruction, 0 = bubble
fetch_stall  output  1  1 = waiting on imem (REQ state, imem_ready=0)

Behaviour:
- Reset (async): PC=RESET_PC; IFID_PC4=0; IFID_Instr=NOP_INSTR; IFID_Valid=0; state=REQ; buffer empty. Reset mid-handshake abandons the request with no replay.
- adv = PCWrite & IFIDWrite.
- BranchTaken is honoured only when PCWrite=1; when PCWrite=0 it is ignored, because the branch in ID is itself stalled.
- Memory contract: imem_addr may change while imem_ready=0; memory answers the address present in the cycle imem_ready=1. Fetch latency is 1 cycle minimum, unbounded maximum.
- imem_req=1 only in REQ. imem_addr=PC always.
- FSM states: REQ (awaiting instruction) and BUF (instruction held in buffer, IF/ID stalled).
- REQ, imem_ready=1, adv=1:
  - IF/ID <= {PC+4, imem_rdata, 1}
  - PC <= PC+4
  - stay in REQ
- REQ, imem_ready=1, adv=0:
  - buffer <= {PC+4, imem_rdata}
  - PC holds
  - IF/ID holds
  - go to BUF
- REQ, imem_ready=0:
  - PC holds
  - if IFIDWrite=1: IF/ID <= {0, NOP_INSTR, 0} (bubble); else IF/ID holds
  - fetch_stall=1
- BUF, adv=1:
  - IF/ID <= {buffer, 1}
  - PC <= PC+4
  - go to REQ
- BUF, adv=0: everything holds.
- BranchTaken & PCWrite, in any state, with priority over all rows above:
  - PC <= BranchTarget
  - IF/ID <= {0, NOP_INSTR, 0}
  - buffer discarded; state <= REQ
  - an imem_ready arriving the same cycle is dropped
- PCWrite=1 with IFIDWrite=0 and no branch: treated as a stall (adv=0), so PC never runs ahead of IF/ID.
- PC+4 is 32-bit and wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- BranchTarget bits [1:0] are forced to 0 when loaded.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds output BubbleCnt[31:0].
  - Reset to 0.
  - Increments every cycle IF/ID loads a bubble, from either imem wait or flush.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset with RESET_PC=32'h0040_0000, imem_ready tied 1, rdata=addr^32'hA5A5_A5A5 -> after 3 edges PC=32'h0040_000C, IFID_PC4=32'h0040_000C, IFID_Instr=32'h0040_0008^32'hA5A5_A5A5, Valid=1.
- Hold PCWrite=IFIDWrite=0 for 2 cycles with imem_ready=1 -> PC, IFID_* unchanged; FSM in BUF, imem_req=0; on release, buffered word enters IF/ID, then fetch resumes at PC+4 with no loss or duplication.
- imem_ready=0 for 3 cycles -> fetch_stall=1, IFID_Valid=0, IFID_Instr=NOP_INSTR for 3 cycles, PC constant; BubbleCnt=3 when FETCH_PERF_EN is defined.
- BranchTaken=1, BranchTarget=32'h0000_1003 while in BUF -> next edge PC=32'h0000_1000, IFID_Valid=0, buffer dropped, state REQ.
- BranchTaken=1 with PCWrite=0 -> ignored; PC and IF/ID hold.
- PC=32'hFFFF_FFFC, fetch completes -> PC=0, IFID_PC4=0; assert reset mid-wait -> outputs take reset values before the next clk edge.
